fm_freq_detect: RTL and testbench

Frequency detector for the FM path: the receive-side counterpart of the NCO. It takes the signed 16-bit sine samples an NCO produces, finds rising zero crossings with hysteresis, and counts clock cycles over a window of periods. A sequential restoring divider then turns that count back into the 32-bit frequency control word, where frequency = clk * ctrl / 2^32. Its output drives FM demodulation and loopback self-test of the NCO.

---
 rtl/fm_freq_detect.sv | 244 ++++++++++++++++++++++++
 tb/tb_fm_freq_detect.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fm_freq_detect.sv
// rtl/fm_freq_detect.sv - zero-crossing frequency detector producing an NCO control word
module fm_freq_detect #(
    parameter logic [15:0] HYST     = 16'd256,
    parameter int          AVG_LOG2 = 2,
    parameter logic [31:0] TIMEOUT  = 32'hFFFF_FFFF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [15:0] sample_in,
    input  logic               sample_valid,
    output logic [31:0]        ctrl_out,
    output logic               out_valid,
    output logic               no_signal,
    output logic               overrun
);

    // Periods per window; also the dividend's high part 2^AVG_LOG2.
    localparam int          PERIODS_I = 1 << AVG_LOG2;
    localparam logic [4:0]  PERIODS   = PERIODS_I[4:0];

    // Thresholds in 17-bit signed so +HYST and -HYST are both representable.
    localparam logic signed [16:0] HYST_P = {1'b0, HYST};
    localparam logic signed [16:0] HYST_N = -HYST_P;

    typedef enum logic {
        WAIT_FIRST,
        MEASURE
    } win_state_t;

    typedef enum logic [1:0] {
        D_IDLE,
        D_DIV,
        D_DONE
    } div_state_t;

    // ------------------------------------------------------------------
    // Crossing detector
    // ------------------------------------------------------------------
    logic               r_arm;
    logic signed [16:0] w_sample_ext;
    logic               w_hi;
    logic               w_lo;
    logic               w_cross;

    assign w_sample_ext = {sample_in[15], sample_in};
    assign w_hi         = (w_sample_ext >= HYST_P);
    assign w_lo         = (w_sample_ext <= HYST_N);
    assign w_cross      = sample_valid && r_arm && w_hi;

    // Arm on a clearly negative sample, disarm on the crossing back above +HYST.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_arm <= 1'b0;
        end else if (sample_valid) begin
            if (w_lo) begin
                r_arm <= 1'b1;
            end else if (w_hi) begin
                r_arm <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Window FSM and cycle/period counters
    // ------------------------------------------------------------------
    win_state_t  r_win;
    win_state_t  w_win_next;
    logic [31:0] r_cyc;
    logic [4:0]  r_pcnt;
    logic [32:0] w_cyc_inc;
    logic [4:0]  w_pcnt_inc;
    logic        w_timeout;
    logic        w_open;
    logic        w_close;
    logic [31:0] w_period_sum;

    // w_cyc_inc is the count the closing edge itself would produce, i.e. the
    // number of edges from the opening crossing to this one.
    assign w_cyc_inc    = {1'b0, r_cyc} + 33'd1;
    assign w_pcnt_inc   = r_pcnt + 5'd1;
    assign w_timeout    = (r_win == MEASURE) && (w_cyc_inc >= {1'b0, TIMEOUT});
    assign w_period_sum = w_cyc_inc[31:0];

    // Window state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_win <= WAIT_FIRST;
        end else begin
            r_win <= w_win_next;
        end
    end

    // Window next state; a timeout on the same edge as a crossing wins.
    always_comb begin
        w_win_next = r_win;
        w_open     = 1'b0;
        w_close    = 1'b0;
        case (r_win)
            WAIT_FIRST: begin
                if (w_cross) begin
                    w_open     = 1'b1;
                    w_win_next = MEASURE;
                end
            end
            MEASURE: begin
                if (w_timeout) begin
                    w_win_next = WAIT_FIRST;
                end else if (w_cross && (w_pcnt_inc == PERIODS)) begin
                    w_close = 1'b1;
                end
            end
            default: begin
                w_win_next = WAIT_FIRST;
            end
        endcase
    end

    // Cycle and period counters; closing crossing restarts them so windows abut.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cyc  <= 32'd0;
            r_pcnt <= 5'd0;
        end else if (w_open || w_close || w_timeout) begin
            r_cyc  <= 32'd0;
            r_pcnt <= 5'd0;
        end else if (r_win == MEASURE) begin
            r_cyc <= w_cyc_inc[31:0];
            if (w_cross) begin
                r_pcnt <= w_pcnt_inc;
            end
        end
    end

    // ------------------------------------------------------------------
    // Restoring divider: Q = floor(2^(32+AVG_LOG2) / T)
    // ------------------------------------------------------------------
    div_state_t  r_div;
    div_state_t  w_div_next;
    logic [31:0] r_den;
    logic [32:0] r_rem;
    logic [31:0] r_quo;
    logic [4:0]  r_iter;
    logic        r_sat;
    logic        w_load;
    logic        w_drop;
    logic [32:0] w_rem2;
    logic        w_ge;
    logic [32:0] w_sub;

    assign w_load = w_close && (r_div == D_IDLE);
    assign w_drop = w_close && (r_div != D_IDLE);
    assign w_rem2 = r_rem << 1;
    assign w_ge   = (w_rem2 >= {1'b0, r_den});
    assign w_sub  = w_rem2 - {1'b0, r_den};

    // Divider state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div <= D_IDLE;
        end else begin
            r_div <= w_div_next;
        end
    end

    // Divider next state: 32 iterations, then one cycle to publish.
    always_comb begin
        w_div_next = r_div;
        case (r_div)
            D_IDLE: begin
                if (w_close) begin
                    w_div_next = D_DIV;
                end
            end
            D_DIV: begin
                if (r_iter == 5'd31) begin
                    w_div_next = D_DONE;
                end
            end
            D_DONE: begin
                w_div_next = D_IDLE;
            end
            default: begin
                w_div_next = D_IDLE;
            end
        endcase
    end

    // Datapath: the remainder starts at 2^AVG_LOG2 (the dividend's high part)
    // and shifts in zero bits; T <= 2^AVG_LOG2 means the quotient overflows.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_den  <= 32'd0;
            r_rem  <= 33'd0;
            r_quo  <= 32'd0;
            r_iter <= 5'd0;
            r_sat  <= 1'b0;
        end else if (w_load) begin
            r_den  <= w_period_sum;
            r_rem  <= {28'd0, PERIODS};
            r_quo  <= 32'd0;
            r_iter <= 5'd0;
            r_sat  <= (w_period_sum <= {27'd0, PERIODS});
        end else if (r_div == D_DIV) begin
            r_rem  <= w_ge ? w_sub : w_rem2;
            r_quo  <= {r_quo[30:0], w_ge};
            r_iter <= r_iter + 5'd1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs and status flags
    // ------------------------------------------------------------------

    // Publish the quotient with a one-cycle valid pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_out  <= 32'd0;
            out_valid <= 1'b0;
        end else if (r_div == D_DONE) begin
            ctrl_out  <= r_sat ? 32'hFFFF_FFFF : r_quo;
            out_valid <= 1'b1;
        end else begin
            out_valid <= 1'b0;
        end
    end

    // no_signal set on timeout, cleared by the next result; overrun is sticky.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            no_signal <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (w_timeout) begin
                no_signal <= 1'b1;
            end else if (r_div == D_DONE) begin
                no_signal <= 1'b0;
            end
            if (w_drop) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fm_freq_detect.sv
// tb/tb_fm_freq_detect.sv - scoreboard bench for fm_freq_detect
module tb_fm_freq_detect;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic signed [15:0] sample_in = 16'sd0;
    logic               sample_valid = 1'b0;
    logic [31:0]        ctrl_out;
    logic               out_valid;
    logic               no_signal;
    logic               overrun;

    always #5 clk = ~clk;

    fm_freq_detect #(
        .HYST     (16'd256),
        .AVG_LOG2 (2),
        .TIMEOUT  (32'd1000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .ctrl_out     (ctrl_out),
        .out_valid    (out_valid),
        .no_signal    (no_signal),
        .overrun      (overrun)
    );

    int          total = 0;
    int          bad   = 0;
    int unsigned cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] q;
        int unsigned at;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;

    bit          wf_open;
    int          pcnt;
    int unsigned free_at;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // monitor: every out_valid pops one expected result and checks value and edge
    always @(negedge clk) begin
        if (rst && out_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("ctrl_out", ctrl_out, mon_e.q);
                check("latency", cyc, mon_e.at);
            end
        end
    end

    task automatic check_reset_outputs();
        check("rst_ctrl_out", ctrl_out, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_no_signal", {31'd0, no_signal}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
    endtask

    task automatic clear_model();
        wf_open = 1'b0;
        pcnt    = 0;
        free_at = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst          = 1'b0;
        sample_valid = 1'b0;
        sample_in    = 16'sd0;
        repeat (2) @(negedge clk);
        check_reset_outputs();
        rst = 1'b1;
        clear_model();
    endtask

    // crossing accepted at edge k: open, count, close every 4 periods
    task automatic note_crossing(input int unsigned k, input logic [31:0] q);
        exp_t e;
        if (!wf_open) begin
            wf_open = 1'b1;
            pcnt    = 0;
        end else begin
            pcnt++;
            if (pcnt == 4) begin
                pcnt = 0;
                if (k >= free_at) begin
                    e.q  = q;
                    e.at = k + 33;
                    sb.push_back(e);
                    free_at = k + 34;
                end
            end
        end
    endtask

    // square wave +-20000, low half first; crossing on the first high sample
    task automatic send_wave(input int period, input int nper, input logic [31:0] q);
        for (int p = 0; p < nper; p++) begin
            for (int i = 0; i < period; i++) begin
                @(negedge clk);
                sample_valid = 1'b1;
                sample_in    = (i < period / 2) ? -16'sd20000 : 16'sd20000;
                if (i == period / 2) note_crossing(cyc + 1, q);
            end
        end
    endtask

    task automatic drain();
        @(negedge clk);
        sample_valid = 1'b0;
        for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int          v;
        int unsigned e0;
        int unsigned kk;
        int          ncross;

        // lock at 2^26: period 64, four windows back to back
        do_reset();
        send_wave(64, 17, 32'h0400_0000);
        drain();
        check("lock_overrun_clear", {31'd0, overrun}, 32'd0);

        // non-power-of-two period: T = 400
        do_reset();
        send_wave(100, 6, 32'h028F_5C28);
        drain();

        // hysteresis: small noise never arms, so a later high burst is not a crossing
        do_reset();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            sample_valid = 1'b1;
            v = int'($urandom_range(400)) - 200;
            sample_in = v[15:0];
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            sample_in = 16'sd20000;
        end
        send_wave(64, 6, 32'h0400_0000);
        drain();

        // timeout: one crossing then zeros, flag exactly 1000 edges later
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            sample_valid = 1'b1;
            sample_in    = -16'sd20000;
        end
        @(negedge clk);
        sample_in = 16'sd20000;
        e0 = cyc + 1;
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk);
            sample_in = 16'sd0;
            if (cyc == e0 + 999) check("no_signal_before", {31'd0, no_signal}, 32'd0);
            if (cyc == e0 + 1000) begin
                check("no_signal_set", {31'd0, no_signal}, 32'd1);
                break;
            end
        end
        send_wave(64, 6, 32'h0400_0000);
        drain();
        check("no_signal_cleared", {31'd0, no_signal}, 32'd0);

        // overrun: period 4, T = 16, only every third close is accepted
        do_reset();
        send_wave(4, 30, 32'h4000_0000);
        drain();
        check("overrun_set", {31'd0, overrun}, 32'd1);

        // reset mid-divide: abort 10 edges after the closing crossing
        do_reset();
        ncross = 0;
        kk     = 0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            sample_valid = 1'b1;
            sample_in    = ((n % 64) < 32) ? -16'sd20000 : 16'sd20000;
            if ((n % 64) == 32) begin
                ncross++;
                if (ncross == 5) kk = cyc + 1;
            end
            if (ncross == 5 && (cyc + 1) >= kk + 10) break;
        end
        rst          = 1'b0;
        sample_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs();
        rst = 1'b1;
        clear_model();
        send_wave(64, 6, 32'h0400_0000);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
